// File: rtl/yaya_istek_denetleyici.sv
// Pedestrian-request front end: synchronises and debounces the push-button, then hands one
// crossing request to the traffic-light sequencer. A cooldown follows each served request.
module yaya_istek_denetleyici #(
  parameter int DEBOUNCE_CYCLES = 400_000,
  parameter int COOLDOWN_CYCLES = 200_000_000,
  parameter int BLINK_CYCLES    = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       ped_ack,
  output logic       ped_req,
  output logic       led_wait,
  output logic [7:0] press_count
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int COOL_W  = $clog2(COOLDOWN_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_CYCLES);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COOL_W-1:0]  COOL_LOAD  = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ACKLO = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t state, state_d;

  logic s1, s2, deb, deb_d;
  logic [DEB_W-1:0] deb_cnt;
  logic press;

  logic [COOL_W-1:0]  cool_cnt;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_d;
  logic blink, blink_d;
  logic req_d, led_d;

  // Input conditioning: every level is 1 (released) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      deb     <= 1'b1;
      deb_d   <= 1'b1;
      deb_cnt <= '0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      deb_d <= deb;
      if (s2 != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Single-cycle pulse on the debounced press edge; releases are silent.
  assign press = deb_d & ~deb;

  // Four-phase handshake: ped_req rises and holds until ped_ack is seen high, then drops;
  // the sequencer must lower ped_ack before the cooldown starts and a new request may follow.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (press)            state_d = PEND;
      PEND:    if (ped_ack)          state_d = ACKLO;
      ACKLO:   if (!ped_ack)         state_d = COOL;
      COOL:    if (cool_cnt == '0)   state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt;
    blink_d     = blink;
    if (state_d == PEND && state != PEND) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state == PEND) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink;
      end else begin
        blink_cnt_d = blink_cnt + 1'b1;
      end
    end
    req_d = (state_d == PEND);
    unique case (state_d)
      IDLE:    led_d = 1'b1;
      PEND:    led_d = blink_d;
      ACKLO:   led_d = 1'b0;
      COOL:    led_d = 1'b1;
      default: led_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cool_cnt    <= '0;
      blink_cnt   <= '0;
      blink       <= 1'b0;
      ped_req     <= 1'b0;
      led_wait    <= 1'b1;
      press_count <= '0;
    end else begin
      state     <= state_d;
      blink_cnt <= blink_cnt_d;
      blink     <= blink_d;
      ped_req   <= req_d;
      led_wait  <= led_d;
      if (state == ACKLO && state_d == COOL) begin
        cool_cnt <= COOL_LOAD;
      end else if (state == COOL && cool_cnt != '0) begin
        cool_cnt <= cool_cnt - 1'b1;
      end
      if (state == IDLE && press && press_count != 8'd255) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_yaya_istek_denetleyici.sv
// Directed bench for the pedestrian-request front end, with short debounce, cooldown and blink
// periods so every timing boundary can be hit cycle-exactly.
module tb_yaya_istek_denetleyici;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       ped_ack;
  logic       ped_req;
  logic       led_wait;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  yaya_istek_denetleyici #(
    .DEBOUNCE_CYCLES(8),
    .COOLDOWN_CYCLES(20),
    .BLINK_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .ped_ack(ped_ack),
    .ped_req(ped_req),
    .led_wait(led_wait),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected completion");
    $fatal(1);
  end

  // Drive and sample 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_n = 1'b1; ped_ack = 1'b0;
    tick(); tick();
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b1 || press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b led=%b cnt=%0d, expected req=0 led=1 cnt=0",
               ped_req, led_wait, press_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      btn_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    btn_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (ped_req !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_req: cycle %0d got req=%b, expected 0", i, ped_req);
      end
    end
    n_checks++;
    if (press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d, expected 0", press_count);
    end
  endtask

  task automatic test_clean_press();
    btn_n = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) begin
        n_checks++;
        if (ped_req !== 1'b0) begin
          n_fail++;
          $display("FAIL press_latency_early: edge 10 got req=%b, expected 0", ped_req);
        end
      end
    end
    n_checks++;
    if (ped_req !== 1'b1 || led_wait !== 1'b0 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL press_edge11: got req=%b led=%b cnt=%0d, expected req=1 led=0 cnt=1",
               ped_req, led_wait, press_count);
    end
    btn_n = 1'b1;
  endtask

  // Entered right after the PEND entry edge; ends right after the next PEND entry edge.
  task automatic test_handshake();
    tick();
    n_checks++;
    if (ped_req !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_req_held: got req=%b, expected 1", ped_req);
    end
    ped_ack = 1'b1;
    tick();
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_ack_edge: got req=%b led=%b, expected req=0 led=0", ped_req, led_wait);
    end
    for (int j = 3; j <= 6; j++) begin
      tick();
      n_checks++;
      if (ped_req !== 1'b0 || led_wait !== 1'b0) begin
        n_fail++;
        $display("FAIL hs_acklo: edge %0d got req=%b led=%b, expected req=0 led=0",
                 j, ped_req, led_wait);
      end
    end
    ped_ack = 1'b0;
    tick();
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_cool_entry: got req=%b led=%b, expected req=0 led=1", ped_req, led_wait);
    end
    // Press timed so the FSM sees it on the first IDLE cycle (edge X+21).
    for (int j = 1; j <= 10; j++) tick();
    btn_n = 1'b0;
    for (int j = 11; j <= 20; j++) tick();
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_idle_entry: got req=%b led=%b, expected req=0 led=1", ped_req, led_wait);
    end
    tick();
    n_checks++;
    if (ped_req !== 1'b1 || press_count !== 8'd2) begin
      n_fail++;
      $display("FAIL hs_press_at_idle_entry: got req=%b cnt=%0d, expected req=1 cnt=2",
               ped_req, press_count);
    end
    btn_n = 1'b1;
  endtask

  // Press lands on the last COOL cycle and must be discarded.
  task automatic test_cool_press();
    ped_ack = 1'b1;
    tick();
    ped_ack = 1'b0;
    tick();
    for (int j = 1; j <= 9; j++) tick();
    btn_n = 1'b0;
    for (int j = 10; j <= 25; j++) begin
      tick();
      n_checks++;
      if (ped_req !== 1'b0) begin
        n_fail++;
        $display("FAIL cool_press_req: edge %0d got req=%b, expected 0", j, ped_req);
      end
    end
    n_checks++;
    if (press_count !== 8'd2) begin
      n_fail++;
      $display("FAIL cool_press_count: got %0d, expected 2", press_count);
    end
    btn_n = 1'b1;
    for (int j = 0; j < 14; j++) tick();
  endtask

  task automatic test_blink();
    logic [19:0] pat;
    pat = 20'b0000_1111_0000_1111_0000;
    btn_n = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    btn_n = 1'b1;
    n_checks++;
    if (ped_req !== 1'b1 || press_count !== 8'd3) begin
      n_fail++;
      $display("FAIL blink_entry: got req=%b cnt=%0d, expected req=1 cnt=3", ped_req, press_count);
    end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (led_wait !== pat[19-k]) begin
        n_fail++;
        $display("FAIL blink_pattern: offset %0d got led=%b, expected %b", k, led_wait, pat[19-k]);
      end
    end
  endtask

  task automatic test_pend_press();
    btn_n = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    btn_n = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    n_checks++;
    if (ped_req !== 1'b1 || press_count !== 8'd3) begin
      n_fail++;
      $display("FAIL pend_press: got req=%b cnt=%0d, expected req=1 cnt=3", ped_req, press_count);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b1 || press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got req=%b led=%b cnt=%0d, expected req=0 led=1 cnt=0",
               ped_req, led_wait, press_count);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ack_early();
    ped_ack = 1'b1;
    btn_n = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_idle_ignored: got req=%b led=%b, expected req=0 led=1", ped_req, led_wait);
    end
    tick();
    n_checks++;
    if (ped_req !== 1'b1 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL ack_early_req: got req=%b cnt=%0d, expected req=1 cnt=1", ped_req, press_count);
    end
    tick();
    n_checks++;
    if (ped_req !== 1'b0 || led_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_early_acklo: got req=%b led=%b, expected req=0 led=0", ped_req, led_wait);
    end
    ped_ack = 1'b0;
    btn_n = 1'b1;
    tick();
    n_checks++;
    if (led_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_early_cool: got led=%b, expected 1", led_wait);
    end
    for (int k = 0; k < 25; k++) tick();
  endtask

  task automatic test_saturation();
    int t;
    int exp_count;
    exp_count = 1;
    for (int n = 0; n < 260; n++) begin
      btn_n = 1'b0;
      t = 0;
      while (ped_req !== 1'b1 && t < 30) begin
        tick();
        t++;
      end
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      n_checks++;
      if (ped_req !== 1'b1 || press_count !== 8'(exp_count)) begin
        n_fail++;
        $display("FAIL sat_cycle: iter %0d got req=%b cnt=%0d, expected req=1 cnt=%0d",
                 n, ped_req, press_count, exp_count);
      end
      ped_ack = 1'b1;
      btn_n = 1'b1;
      tick();
      ped_ack = 1'b0;
      for (int k = 0; k < 25; k++) tick();
    end
    n_checks++;
    if (press_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: got %0d, expected 255", press_count);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_handshake();
    test_cool_press();
    test_blink();
    test_pend_press();
    test_reset_mid();
    test_ack_early();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
